// File: rtl/gray_ptr_sync_if.sv
// gray_ptr_sync_if: pointer-sync bus; master drives flush/ptr_in/err_clr, slave returns synchronised pointer status
interface gray_ptr_sync_if #(parameter int ADDRBITS = 8);
  localparam int W = ADDRBITS + 1;
  logic flush;
  logic err_clr;
  logic [W-1:0] ptr_in;
  logic [W-1:0] sync_gray;
  logic [W-1:0] sync_bin;
  logic [W-1:0] advance;
  logic valid;
  logic err_multibit;
  modport master(output flush, err_clr, ptr_in,
                 input sync_gray, sync_bin, advance, valid, err_multibit);
  modport slave(input flush, err_clr, ptr_in,
                output sync_gray, sync_bin, advance, valid, err_multibit);
endinterface

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: Gray pointer CDC chain with registered binary decode, advance count, warm-up valid and sticky multi-bit error; ports clk_in, rst (sync active-low), bus (flush/ptr_in/err_clr in; sync_gray/sync_bin/advance/valid/err_multibit out)
module gray_ptr_sync #(
  parameter int ADDRBITS = 8,
  parameter int STAGES = 2,
  parameter bit ERR_CHECK = 1
) (
  input logic clk_in,
  input logic rst,
  gray_ptr_sync_if.slave bus
);
  localparam int W = ADDRBITS + 1;
  localparam int CW = $clog2(STAGES + 2);
  localparam logic [CW-1:0] WARM = CW'(STAGES + 1);
  logic [W-1:0] s [STAGES];
  logic [W-1:0] gray_q, bin_q, adv_q, bin_d, diff;
  logic [CW-1:0] warm;
  logic err_q, det;
  always_comb begin
    for (int i = 0; i < W; i++) bin_d[i] = ^(s[STAGES-1] >> i);
  end
  assign diff = s[STAGES-1] ^ gray_q;
  // x & (x-1) is nonzero exactly when more than one bit of x is set
  assign det = ERR_CHECK && (warm == WARM) && ((diff & (diff - 1'b1)) != '0);
  always_ff @(posedge clk_in) begin
    if (!rst || bus.flush) begin
      for (int k = 0; k < STAGES; k++) s[k] <= '0;
      gray_q <= '0;
      bin_q <= '0;
      adv_q <= '0;
      warm <= '0;
      err_q <= rst && err_q;
    end else begin
      s[0] <= bus.ptr_in;
      for (int k = 1; k < STAGES; k++) s[k] <= s[k-1];
      gray_q <= s[STAGES-1];
      bin_q <= bin_d;
      adv_q <= bin_d - bin_q;
      warm <= (warm == WARM) ? warm : warm + 1'b1;
      err_q <= det || (err_q && !bus.err_clr);
    end
  end
  assign bus.sync_gray = s[STAGES-1];
  assign bus.sync_bin = bin_q;
  assign bus.advance = adv_q;
  assign bus.valid = (warm == WARM);
  assign bus.err_multibit = ERR_CHECK && err_q;
endmodule
